// File: rtl/dec_ascii_tx.sv
// Binary-to-ASCII-decimal formatter: double-dabble conversion of a 16-bit value,
// then the decimal digits (optionally CR LF) are written into the UART TX FIFO.
module dec_ascii_tx #(
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit APPEND_CRLF    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] data_in,
    input  logic        fifo_full,
    output logic [7:0]  fifo_data,
    output logic        wrreq,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [SEL_W-1:0]  SEL_TOP  = SEL_W'(4);
    localparam logic [SEL_W-1:0]  SEL_CR   = SEL_W'(5);
    localparam logic [SEL_W-1:0]  SEL_LF   = SEL_W'(6);
    localparam logic [BYTE_W-1:0] ASCII_0  = 8'h30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [DATA_W-1:0]  bin, bin_d;
    logic [BCD_W-1:0]   bcd, bcd_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [SEL_W-1:0]   sel, sel_d;
    logic [BYTE_W-1:0]  fifo_data_d;
    logic               wrreq_d, busy_d, done_d;

    logic [BCD_W-2:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [SEL_W-1:0]   start_idx;
    logic [SEL_W-1:0]   sel_adv;
    logic [BYTE_W-1:0]  cur_byte;
    logic               last_byte;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? 4'(n + 4'd3) : n;
    endfunction

    // One double-dabble step; the top digit never exceeds 6, so its MSB is dropped.
    always_comb begin
        bcd_adj   = {3'(add3(bcd[19:16])), add3(bcd[15:12]), add3(bcd[11:8]),
                     add3(bcd[7:4]), add3(bcd[3:0])};
        bcd_shift = {bcd_adj, bin[DATA_W-1]};
    end

    // First digit to send, taken from the final BCD value on the last convert step.
    always_comb begin
        start_idx = SEL_TOP;
        if (SUPPRESS_ZEROS) begin
            if      (bcd_shift[19:16] != 4'd0) start_idx = SEL_W'(4);
            else if (bcd_shift[15:12] != 4'd0) start_idx = SEL_W'(3);
            else if (bcd_shift[11:8]  != 4'd0) start_idx = SEL_W'(2);
            else if (bcd_shift[7:4]   != 4'd0) start_idx = SEL_W'(1);
            else                               start_idx = SEL_W'(0);
        end
    end

    // sel walks digit indices 4..0, then the CR and LF slots.
    always_comb begin
        cur_byte = 8'h0A;
        case (sel)
            SEL_W'(0): cur_byte = ASCII_0 + BYTE_W'(bcd[3:0]);
            SEL_W'(1): cur_byte = ASCII_0 + BYTE_W'(bcd[7:4]);
            SEL_W'(2): cur_byte = ASCII_0 + BYTE_W'(bcd[11:8]);
            SEL_W'(3): cur_byte = ASCII_0 + BYTE_W'(bcd[15:12]);
            SEL_W'(4): cur_byte = ASCII_0 + BYTE_W'(bcd[19:16]);
            SEL_CR:    cur_byte = 8'h0D;
            default:   cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        last_byte = APPEND_CRLF ? (sel == SEL_LF) : (sel == SEL_W'(0));
        if (sel == SEL_W'(0))   sel_adv = SEL_CR;
        else if (sel == SEL_CR) sel_adv = SEL_LF;
        else                    sel_adv = SEL_W'(sel - SEL_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)            state_nx = CONVERT;
            CONVERT: if (cnt == CNT_LAST)  state_nx = EMIT;
            EMIT:    if (!fifo_full)       state_nx = GAP;
            GAP:     state_nx = last_byte ? IDLE : EMIT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bin_d       = bin;
        bcd_d       = bcd;
        cnt_d       = cnt;
        sel_d       = sel;
        fifo_data_d = fifo_data;
        wrreq_d     = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    bin_d = data_in;
                    bcd_d = '0;
                    cnt_d = '0;
                end
            end
            CONVERT: begin
                bin_d = {bin[DATA_W-2:0], 1'b0};
                bcd_d = bcd_shift;
                cnt_d = CNT_W'(cnt + CNT_W'(1));
                if (cnt == CNT_LAST) sel_d = start_idx;
            end
            EMIT: begin
                if (!fifo_full) begin
                    wrreq_d     = 1'b1;
                    fifo_data_d = cur_byte;
                end
            end
            GAP: begin
                if (last_byte) done_d = 1'b1;
                else           sel_d  = sel_adv;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            sel       <= '0;
            fifo_data <= '0;
            wrreq     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bin       <= bin_d;
            bcd       <= bcd_d;
            cnt       <= cnt_d;
            sel       <= sel_d;
            fifo_data <= fifo_data_d;
            wrreq     <= wrreq_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_dec_ascii_tx.sv
// Bench for dec_ascii_tx: two instances (zero-suppress + CRLF, and fixed 5 digits
// without CRLF) checked against a string-formatting reference model.
module tb_dec_ascii_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, full_a, full_b;
    logic [15:0] data_a, data_b;
    logic [7:0]  fd_a, fd_b;
    logic        wr_a, wr_b, busy_a, busy_b, done_a, done_b;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dec_ascii_tx #(.SUPPRESS_ZEROS(1'b1), .APPEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_a),
        .fifo_full(full_a), .fifo_data(fd_a), .wrreq(wr_a), .busy(busy_a), .done(done_a));

    dec_ascii_tx #(.SUPPRESS_ZEROS(1'b0), .APPEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_b),
        .fifo_full(full_b), .fifo_data(fd_b), .wrreq(wr_b), .busy(busy_b), .done(done_b));

    task automatic chk(input string tag, input int obs, input int expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: the decimal text of the value, optionally zero-padded, plus CR LF.
    task automatic model(input bit b, input int v, output byte q[$]);
        string s;
        q = {};
        s = b ? $sformatf("%05d", v) : $sformatf("%0d", v);
        for (int i = 0; i < s.len(); i++) q.push_back(byte'(s[i]));
        if (!b) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
    endtask

    task automatic drv(input bit b, input logic st, input logic [15:0] d);
        if (b) begin start_b = st; data_b = d; end
        else   begin start_a = st; data_a = d; end
    endtask

    task automatic set_full(input bit b, input logic f);
        if (b) full_b = f; else full_a = f;
    endtask

    // Runs one frame; inject_at>0 pulses a start while busy, chain>=0 starts a new
    // frame in the done cycle (the following call then passes pre=1).
    task automatic run_frame(input bit b, input int v, input bit pre, input int stall_len,
                             input int inject_at, input int inject_val, input int chain);
        byte  expq[$];
        byte  got[$];
        int   done_k, first_wr, stall_from, proto_err, busy_drop, n;
        logic wr, dn, bs, prev_wr, full_now;
        logic [7:0] fd;
        string tg;
        model(b, v, expq);
        n = expq.size();
        done_k = -1; first_wr = -1; stall_from = -1;
        proto_err = 0; busy_drop = 0; prev_wr = 1'b0;
        tg = $sformatf("%s_%0d", b ? "b" : "a", v);
        if (!pre) begin
            @(negedge clk);
            drv(b, 1'b1, 16'(v));
        end
        @(posedge clk); #1;
        drv(b, 1'b0, 16'($urandom));
        chk({tg, "_busy_e0"}, int'(b ? busy_b : busy_a), 1);
        chk({tg, "_done_e0"}, int'(b ? done_b : done_a), 0);
        for (int k = 1; k <= 200; k++) begin
            full_now = b ? full_b : full_a;
            @(posedge clk); #1;
            wr = b ? wr_b : wr_a;
            fd = b ? fd_b : fd_a;
            bs = b ? busy_b : busy_a;
            dn = b ? done_b : done_a;
            if (wr) got.push_back(fd);
            if (wr && (prev_wr || full_now)) proto_err++;
            prev_wr = wr;
            if (wr && first_wr < 0) begin
                first_wr = k;
                stall_from = k + 1;
            end
            if (dn) begin
                done_k = k;
                chk({tg, "_busy_end"}, int'(bs), 0);
                if (chain >= 0) drv(b, 1'b1, 16'(chain));
                break;
            end
            if (!bs) busy_drop++;
            drv(b, 1'b0, 16'($urandom));
            if (k == inject_at) drv(b, 1'b1, 16'(inject_val));
            if (stall_len > 0 && k == stall_from) set_full(b, 1'b1);
            if (stall_len > 0 && k == stall_from + stall_len) set_full(b, 1'b0);
        end
        set_full(b, 1'b0);
        chk({tg, "_timeout"}, int'(done_k >= 0), 1);
        chk({tg, "_done_edge"}, done_k, 16 + 2 * n + stall_len);
        chk({tg, "_first_wr"}, first_wr, 17);
        chk({tg, "_nbytes"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tg, i), int'(got[i]), int'(expq[i]));
        chk({tg, "_proto"}, proto_err, 0);
        chk({tg, "_busy_hold"}, busy_drop, 0);
        if (chain < 0) begin
            @(posedge clk); #1;
            chk({tg, "_done_pulse"}, int'(b ? done_b : done_a), 0);
            chk({tg, "_post_wr"}, int'(b ? wr_b : wr_a), 0);
        end
    endtask

    initial begin
        int extra;
        int v, sl;
        bit b;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; full_a = 1'b0; full_b = 1'b0;
        data_a = '0; data_b = '0;
        #12;
        chk("rst_wr",   int'(wr_a),   0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_fd",   int'(fd_a),   0);
        chk("rst_fd_b", int'(fd_b),   0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(1'b0, 12345, 1'b0, 0, 0, 0, -1);
        run_frame(1'b0, 0,     1'b0, 0, 0, 0, -1);
        run_frame(1'b0, 65535, 1'b0, 0, 0, 0, -1);
        run_frame(1'b1, 100,   1'b0, 0, 0, 0, -1);
        run_frame(1'b0, 100,   1'b0, 0, 0, 0, -1);
        run_frame(1'b0, 987,   1'b0, 5, 0, 0, -1);
        run_frame(1'b0, 55,    1'b0, 0, 5, 4321, 7);
        run_frame(1'b0, 7,     1'b1, 0, 0, 0, -1);

        // Asynchronous reset in the middle of emitting 12345.
        @(negedge clk); drv(1'b0, 1'b1, 16'd12345);
        @(posedge clk); #1; drv(1'b0, 1'b0, 16'd0);
        repeat (19) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr",   int'(wr_a),   0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_done", int'(done_a), 0);
        chk("arst_fd",   int'(fd_a),   0);
        @(negedge clk); rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (wr_a || busy_a) extra++;
        end
        chk("arst_quiet", extra, 0);
        run_frame(1'b0, 42, 1'b0, 0, 0, 0, -1);

        for (int i = 0; i < 10; i++) begin
            b  = 1'($urandom_range(0, 1));
            v  = int'($urandom & ((32'd1 << $urandom_range(1, 16)) - 32'd1));
            sl = int'($urandom_range(0, 3));
            run_frame(b, v, 1'b0, sl, 0, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
